delay_meter: RTL and testbench

- Measures the latency, in clk cycles, of any single-clock pipeline path, e.g. a chain of delay stages or a correlator datapath.
- Injects a one-cycle marker pulse into the path and counts cycles until the pulse returns at the far end.
- Reports the count so alignment delays elsewhere in the single-bin DFT correlator can be set from measured values instead of hand-counted ones.
- Sits beside the path under test; its probe_out drives the path input and its probe_in taps the path output.

---
 rtl/delay_meter.sv | 112 +++++++++++
 tb/tb_delay_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_meter.sv
// Measures the latency of a single-clock path by firing a one-cycle marker
// into it and counting cycles until the marker returns at the far end.
module delay_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_DELAY = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 probe_out,
  input  logic                 probe_in,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] delay_val
);

  if (longint'(MAX_DELAY) >= (longint'(1) << CNT_WIDTH) - 1) begin : g_chk
    $error("delay_meter: MAX_DELAY must be below 2**CNT_WIDTH - 1");
  end

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_DELAY);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    MEAS,
    FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] delay_val_q, delay_val_d;
  logic                 probe_out_q, probe_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_val_d = delay_val_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = FIRE;
      end
      FIRE: begin
        // probe_out is high this cycle, so a direct loopback reads as 0
        if (probe_in) begin
          delay_val_d = '0;
          done_d      = 1'b1;
          state_d     = FIN;
        end else begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (probe_in) begin
          delay_val_d = cnt_q;
          done_d      = 1'b1;
          state_d     = FIN;
        end else if (cnt_q == MAX_CNT) begin
          delay_val_d = '1;
          timeout_d   = 1'b1;
          state_d     = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they leave flops cleanly
    probe_out_d = (state_d == FIRE);
    busy_d      = (state_d == FIRE) || (state_d == MEAS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      delay_val_q <= '0;
      probe_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_val_q <= delay_val_d;
      probe_out_q <= probe_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign probe_out = probe_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign delay_val = delay_val_q;

endmodule

// File: tb/tb_delay_meter.sv
// Scoreboard bench for delay_meter: a programmable delay line closes the
// loop from probe_out to probe_in; a monitor checks every done/timeout.
module tb_delay_meter;

  localparam int CW = 16;
  localparam int MD = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          probe_out;
  logic          probe_in;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] delay_val;

  delay_meter #(.CNT_WIDTH(CW), .MAX_DELAY(MD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .probe_out (probe_out),
    .probe_in  (probe_in),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .delay_val (delay_val)
  );

  always #5 clk = ~clk;

  logic [63:0] sr = '0;
  int          dly = 0;
  int          dly2 = -1;
  logic        inject = 1'b0;
  logic        tie_low = 1'b0;

  always @(posedge clk) sr <= {sr[62:0], probe_out};

  always_comb begin
    logic tap;
    tap = 1'b0;
    if (dly == 0) tap = probe_out;
    else tap = sr[dly-1];
    if (dly2 > 0) tap = tap | sr[dly2-1];
    probe_in = (tap & ~tie_low) | inject;
  end

  typedef struct {
    bit            to;
    logic [CW-1:0] val;
    int            lat;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fire_cyc = -1;
  int prev_fire = -1;
  int busy_cnt = 0;
  int npulse = 0;
  int exp_period = 0;
  logic [CW-1:0] prev_val = '0;

  task automatic check(string name, longint act, longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (probe_out) begin
        if (exp_period > 0 && prev_fire >= 0)
          check("fire_period", cyc - prev_fire, exp_period);
        prev_fire = cyc;
        fire_cyc  = cyc;
        busy_cnt  = 0;
      end
      if (done || timeout) begin
        npulse++;
        check("done_and_timeout", {31'd0, done & timeout}, 0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: done=%b timeout=%b val=%0d, none pending",
                   done, timeout, delay_val);
        end else begin
          e = sb.pop_front();
          check("timeout_flag", {31'd0, timeout}, e.to);
          check("delay_val", delay_val, e.val);
          check("latency", cyc - fire_cyc, e.lat);
          check("busy_cycles", busy_cnt, e.lat);
          check("busy_in_fin", {31'd0, busy}, 0);
        end
      end else if (delay_val !== prev_val) begin
        check("delay_val_stable", delay_val, prev_val);
      end
      if (busy) busy_cnt++;
    end
    prev_val = delay_val;
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_pulses(int target, int budget);
    int k = 0;
    while (npulse < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (npulse < target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_result: got %0d results, expected %0d", npulse, target);
    end
  endtask

  task automatic measure(int d, bit to, logic [CW-1:0] val, int lat);
    int n0;
    idle(70);
    dly = d;
    n0 = npulse;
    sb.push_back('{to, val, lat});
    pulse_start();
    wait_pulses(n0 + 1, 200);
  endtask

  initial begin
    int n0;
    idle(3);
    check("rst_probe_out", {31'd0, probe_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_timeout", {31'd0, timeout}, 0);
    check("rst_delay_val", delay_val, 0);
    rst = 1'b0;

    measure(0, 1'b0, 16'd0, 1);
    measure(5, 1'b0, 16'd5, 6);
    measure(1, 1'b0, 16'd1, 2);

    // a start pulse mid-measurement must be ignored
    idle(70);
    dly = 37;
    n0 = npulse;
    sb.push_back('{1'b0, 16'd37, 38});
    pulse_start();
    idle(10);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_pulses(n0 + 1, 200);

    idle(70);
    tie_low = 1'b1;
    measure(3, 1'b1, 16'hFFFF, MD + 1);
    tie_low = 1'b0;
    measure(3, 1'b0, 16'd3, 4);

    measure(MD, 1'b0, 16'(MD), MD + 1);
    measure(MD + 1, 1'b1, 16'hFFFF, MD + 1);

    // start held high: back-to-back measurements every delay+3 cycles
    idle(70);
    dly = 4;
    prev_fire = -1;
    exp_period = 7;
    n0 = npulse;
    for (int i = 0; i < 5; i++) sb.push_back('{1'b0, 16'd4, 5});
    start = 1'b1;
    idle(30);
    start = 1'b0;
    wait_pulses(n0 + 5, 100);
    idle(20);
    exp_period = 0;
    check("b2b_count", npulse - n0, 5);

    // reset at cnt=6 aborts; the marker returning later is ignored
    idle(70);
    dly = 10;
    n0 = npulse;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_probe_out", {31'd0, probe_out}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_timeout", {31'd0, timeout}, 0);
    check("abort_delay_val", delay_val, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    check("abort_no_result", npulse - n0, 0);
    check("abort_val_held", delay_val, 0);

    // stray return in IDLE, then a path with a second late return
    idle(70);
    n0 = npulse;
    inject = 1'b1;
    idle(2);
    inject = 1'b0;
    idle(5);
    check("idle_inject", npulse - n0, 0);
    dly2 = 8;
    measure(2, 1'b0, 16'd2, 3);
    idle(20);
    check("second_return", npulse - n0, 1);
    check("second_return_val", delay_val, 2);
    dly2 = -1;

    idle(80);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
